pwm_multi: RTL and testbench

- Multi-channel PWM generator. NumChannels outputs are driven from one shared period counter.
- Each channel has its own duty value and output polarity.
- Supports edge-aligned and center-aligned modes.
- Period and duty values are double-buffered, and new values take effect only at a period boundary, so no output glitches.
- Used by the system for LED/RGB dimming and motor-style outputs. Sits behind a register block that drives its inputs.

---
 rtl/pwm_multi_if.sv | 34 +++
 rtl/pwm_multi.sv | 103 ++++++++++
 tb/tb_pwm_multi.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_if.sv
// ============================================================================
// Module   : pwm_multi_if
// Brief    : Control/status bundle between the register block and pwm_multi.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface pwm_multi_if #(
   parameter int NumChannels = 4,
   parameter int CtrSize     = 16
);
   logic                           en_i;
   logic                           center_align_i;
   logic [CtrSize-1:0]             max_counter_i;
   logic [NumChannels*CtrSize-1:0] pulse_width_i;
   logic [NumChannels-1:0]         invert_i;
   logic                           update_i;
   logic                           update_pending_o;
   logic                           period_end_o;
   logic [NumChannels-1:0]         modulated_o;

   modport slave (
      input  en_i, center_align_i, max_counter_i, pulse_width_i, invert_i, update_i,
      output update_pending_o, period_end_o, modulated_o
   );

   modport master (
      output en_i, center_align_i, max_counter_i, pulse_width_i, invert_i, update_i,
      input  update_pending_o, period_end_o, modulated_o
   );
endinterface

`default_nettype wire

// File: rtl/pwm_multi.sv
// ============================================================================
// Module   : pwm_multi
// Brief    : Multi-channel edge/center-aligned PWM with period-boundary shadow load.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pwm_multi #(
   parameter int NumChannels = 4,
   parameter int CtrSize     = 16
) (
   input  wire logic     clk_i,
   input  wire logic     rst_i,
   pwm_multi_if.slave    bus
);

   localparam logic               c_DIR_UP = 1'b0;
   localparam logic               c_DIR_DN = 1'b1;
   localparam logic [CtrSize-1:0] c_ONE    = {{(CtrSize-1){1'b0}}, 1'b1};

   logic [CtrSize-1:0]     r_cnt;
   logic                   r_dir;
   logic [CtrSize-1:0]     r_max;
   logic                   r_mode;
   logic [CtrSize-1:0]     r_pw [NumChannels];
   logic                   r_pending;
   logic [NumChannels-1:0] r_mod;

   logic [CtrSize-1:0]     w_cnt_nxt;
   logic                   w_dir_nxt;
   logic                   w_running;
   logic                   w_wrap;
   logic                   w_load;
   logic [NumChannels-1:0] w_mod_nxt;

   assign w_running = bus.en_i && (r_max != '0);

   // Next-state: counter/direction sequencing for both alignment modes
   always_comb begin
      w_cnt_nxt = '0;
      w_dir_nxt = c_DIR_UP;
      if (w_running) begin
         if (!r_mode) begin
            if (r_cnt != r_max) w_cnt_nxt = r_cnt + c_ONE;
         end else if (r_dir == c_DIR_UP) begin
            if (r_cnt != r_max) begin
               w_cnt_nxt = r_cnt + c_ONE;
            end else if (r_max != c_ONE) begin
               w_cnt_nxt = r_max - c_ONE;
               w_dir_nxt = c_DIR_DN;
            end
         end else begin
            if (r_cnt != c_ONE) begin
               w_cnt_nxt = r_cnt - c_ONE;
               w_dir_nxt = c_DIR_DN;
            end
         end
      end
   end

   // Outputs/decodes: the wrap cycle is the only safe point to swap shadows
   always_comb begin
      w_wrap = w_running && (w_cnt_nxt == '0);
      w_load = (bus.update_i || r_pending) && (!w_running || w_wrap);
   end

   for (genvar c = 0; c < NumChannels; c++) begin : g_ch
      assign w_mod_nxt[c] = (w_running && (r_pw[c] > r_cnt)) ^ bus.invert_i[c];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt     <= '0;
         r_dir     <= c_DIR_UP;
         r_max     <= '0;
         r_mode    <= 1'b0;
         r_pending <= 1'b0;
         r_mod     <= '0;
         for (int c = 0; c < NumChannels; c++) r_pw[c] <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_dir <= w_load ? c_DIR_UP : w_dir_nxt;
         r_mod <= w_mod_nxt;
         if (w_load) begin
            r_max     <= bus.max_counter_i;
            r_mode    <= bus.center_align_i;
            r_pending <= 1'b0;
            for (int c = 0; c < NumChannels; c++)
               r_pw[c] <= bus.pulse_width_i[c*CtrSize +: CtrSize];
         end else if (bus.update_i) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign bus.update_pending_o = r_pending;
   assign bus.period_end_o     = w_wrap;
   assign bus.modulated_o      = r_mod;

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi.sv
// ============================================================================
// Module   : tb_pwm_multi
// Brief    : Directed self-checking bench for pwm_multi (CtrSize=8, 4 channels).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pwm_multi;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   pwm_multi_if #(.NumChannels(4), .CtrSize(8)) bus ();

   pwm_multi #(.NumChannels(4), .CtrSize(8)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Output pattern per counter value, pw={ch3=4,ch2=5,ch1=2,ch0=0}
   logic [3:0] exp_edge [5] = '{4'b1110, 4'b1110, 4'b1100, 4'b1100, 4'b0100};
   // Center-aligned sequence 0,1,2,3,4,3,2,1 with the same duties
   logic [3:0] exp_ctr  [8] = '{4'b1110, 4'b1110, 4'b1100, 4'b1100,
                                4'b0100, 4'b1100, 4'b1100, 4'b1110};
   // Edge-aligned with ch1 duty reduced to 1
   logic [3:0] exp_new  [5] = '{4'b1110, 4'b1100, 4'b1100, 4'b1100, 4'b0100};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst                = 1'b1;
      bus.en_i           = 1'b0;
      bus.center_align_i = 1'b0;
      bus.max_counter_i  = '0;
      bus.pulse_width_i  = '0;
      bus.invert_i       = '0;
      bus.update_i       = 1'b0;
      tick();
      tick();
      check_eq("rst_mod",  32'(bus.modulated_o), 32'h0);
      check_eq("rst_pend", 32'(bus.update_pending_o), 32'h0);
      check_eq("rst_pe",   32'(bus.period_end_o), 32'h0);
      rst = 1'b0;

      // 1: edge-aligned, M=4
      bus.max_counter_i = 8'd4;
      bus.pulse_width_i = {8'd4, 8'd5, 8'd2, 8'd0};
      bus.update_i = 1'b1;
      tick();
      bus.update_i = 1'b0;
      check_eq("t1_pend", 32'(bus.update_pending_o), 32'h0);
      bus.en_i = 1'b1;
      for (int i = 0; i < 15; i++) begin
         check_eq($sformatf("t1_pe%0d", i), 32'(bus.period_end_o), 32'((i % 5) == 4));
         check_eq($sformatf("t1_mod%0d", i), 32'(bus.modulated_o),
                  (i == 0) ? 32'h0 : 32'(exp_edge[(i-1) % 5]));
         tick();
      end

      // 2: center-aligned, M=4
      bus.en_i = 1'b0;
      tick();
      bus.center_align_i = 1'b1;
      bus.update_i = 1'b1;
      tick();
      bus.update_i = 1'b0;
      bus.en_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check_eq($sformatf("t2_pe%0d", i), 32'(bus.period_end_o), 32'((i % 8) == 7));
         check_eq($sformatf("t2_mod%0d", i), 32'(bus.modulated_o),
                  (i == 0) ? 32'h0 : 32'(exp_ctr[(i-1) % 8]));
         tick();
      end

      // 2b: center-aligned, M=1 with ch1 duty 1
      bus.en_i = 1'b0;
      tick();
      bus.max_counter_i = 8'd1;
      bus.pulse_width_i = {8'd4, 8'd5, 8'd1, 8'd0};
      bus.update_i = 1'b1;
      tick();
      bus.update_i = 1'b0;
      bus.en_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check_eq($sformatf("t2b_pe%0d", i), 32'(bus.period_end_o), 32'((i % 2) == 1));
         if (i > 0)
            check_eq($sformatf("t2b_mod%0d", i), 32'(bus.modulated_o),
                     ((i - 1) % 2 == 0) ? 32'hE : 32'hC);
         tick();
      end

      // 3: shadowed update mid-period
      bus.en_i = 1'b0;
      tick();
      bus.center_align_i = 1'b0;
      bus.max_counter_i  = 8'd4;
      bus.pulse_width_i  = {8'd4, 8'd5, 8'd2, 8'd0};
      bus.update_i = 1'b1;
      tick();
      bus.update_i = 1'b0;
      bus.en_i = 1'b1;
      tick();
      tick();
      bus.pulse_width_i = {8'd4, 8'd5, 8'd1, 8'd0};
      bus.update_i = 1'b1;
      tick();
      bus.update_i = 1'b0;
      check_eq("t3_pend_a", 32'(bus.update_pending_o), 32'h1);
      check_eq("t3_mod_a",  32'(bus.modulated_o), 32'hC);
      check_eq("t3_pe_a",   32'(bus.period_end_o), 32'h0);
      tick();
      check_eq("t3_pend_w", 32'(bus.update_pending_o), 32'h1);
      check_eq("t3_pe_w",   32'(bus.period_end_o), 32'h1);
      check_eq("t3_mod_w",  32'(bus.modulated_o), 32'hC);
      tick();
      check_eq("t3_pend_l", 32'(bus.update_pending_o), 32'h0);
      check_eq("t3_mod_l",  32'(bus.modulated_o), 32'h4);
      bus.max_counter_i = 8'd7;
      for (int j = 1; j <= 10; j++) begin
         tick();
         check_eq($sformatf("t3_mod%0d", j), 32'(bus.modulated_o), 32'(exp_new[(j-1) % 5]));
         check_eq($sformatf("t3_pe%0d", j), 32'(bus.period_end_o), 32'((j % 5) == 4));
      end

      // 4: idle level with M=0, then en_i low
      bus.en_i = 1'b0;
      tick();
      bus.invert_i      = 4'b1010;
      bus.max_counter_i = 8'd0;
      bus.update_i = 1'b1;
      tick();
      bus.update_i = 1'b0;
      bus.en_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("t4_mod%0d", i), 32'(bus.modulated_o), 32'hA);
         check_eq($sformatf("t4_pe%0d", i), 32'(bus.period_end_o), 32'h0);
         tick();
      end
      bus.en_i = 1'b0;
      bus.max_counter_i = 8'd4;
      bus.update_i = 1'b1;
      tick();
      bus.update_i = 1'b0;
      check_eq("t4_dis_pend", 32'(bus.update_pending_o), 32'h0);
      check_eq("t4_dis_mod",  32'(bus.modulated_o), 32'hA);
      check_eq("t4_dis_pe",   32'(bus.period_end_o), 32'h0);
      tick();
      check_eq("t4_dis_mod2", 32'(bus.modulated_o), 32'hA);
      bus.en_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("t4_en_pe%0d", i), 32'(bus.period_end_o), 32'(i == 4));
         if (i == 1) check_eq("t4_en_mod", 32'(bus.modulated_o), 32'h4);
         tick();
      end

      // 5: reset at count 3 with an update pending
      bus.update_i = 1'b1;
      tick();
      bus.update_i = 1'b0;
      check_eq("t5_pend", 32'(bus.update_pending_o), 32'h1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("t5_mod",  32'(bus.modulated_o), 32'h0);
      check_eq("t5_pend0", 32'(bus.update_pending_o), 32'h0);
      check_eq("t5_pe",   32'(bus.period_end_o), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("t5_idle%0d", i), 32'(bus.modulated_o), 32'hA);
         check_eq($sformatf("t5_ipend%0d", i), 32'(bus.update_pending_o), 32'h0);
         check_eq($sformatf("t5_ipe%0d", i), 32'(bus.period_end_o), 32'h0);
      end

      // 6: update on the wrap cycle, M 4 -> 2
      bus.invert_i      = 4'b0000;
      bus.max_counter_i = 8'd4;
      bus.pulse_width_i = {8'd4, 8'd5, 8'd2, 8'd0};
      bus.update_i = 1'b1;
      tick();
      bus.update_i = 1'b0;
      check_eq("t6_pend_a", 32'(bus.update_pending_o), 32'h0);
      for (int i = 0; i < 4; i++) tick();
      check_eq("t6_pe_wrap", 32'(bus.period_end_o), 32'h1);
      bus.max_counter_i = 8'd2;
      bus.update_i = 1'b1;
      tick();
      bus.update_i = 1'b0;
      for (int j = 0; j < 6; j++) begin
         check_eq($sformatf("t6_pe%0d", j), 32'(bus.period_end_o), 32'((j % 3) == 2));
         check_eq($sformatf("t6_pend%0d", j), 32'(bus.update_pending_o), 32'h0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
